// File: rtl/bus_cmd_pkg.sv
// Shared opcode constants, state encoding and width defaults for bus_cmd_decoder.
package bus_cmd_pkg;

    localparam int BUS_ADDR_W = 17;
    localparam int BUS_DATA_W = 8;

    localparam logic [7:0] OP_WRITE      = 8'h80;
    localparam logic [7:0] OP_READ       = 8'hC0;
    localparam logic [7:0] OP_WRITE_NEXT = 8'hA0;
    localparam logic [7:0] OP_READ_NEXT  = 8'hE0;
    localparam logic [7:0] OP_A16_MASK   = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    // Opcode with the A16 bit cleared, for comparison against the OP_* constants.
    function automatic logic [7:0] op_base(input logic [7:0] b);
        return b & ~OP_A16_MASK;
    endfunction

endpackage

// File: rtl/bus_cmd_decoder.sv
// MCU command byte stream -> single 17-bit bus read/write request, read data returned as a tx byte.
// Optional: define BUS_CMD_AUTOINC_EN to enable WRITE_NEXT (0xA0) / READ_NEXT (0xE0).
//
// state    | meaning
// IDLE     | waiting for an opcode byte
// ADDR_HI  | waiting for address bits [15:8]
// ADDR_LO  | waiting for address bits [7:0] (last byte of a READ)
// DATA     | waiting for write data
// ISSUE    | request outstanding, outputs frozen until done
// DRAIN    | bad opcode, ignore bytes until frame drops
module bus_cmd_decoder
    import bus_cmd_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_rw_b,
    output logic              pending,
    input  logic              done,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              overrun
);

    state_t            state_q;
    logic              is_rd_q;
    logic              a16_q;
    logic [7:0]        addr_hi_q;
    logic [7:0]        addr_lo_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic              bus_rw_b_q;
    logic              pending_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              overrun_q;

    logic              rx_ok;
    logic              issue_d;
    logic              issue_rd_d;
    logic [ADDR_W-1:0] cmd_addr_d;

`ifdef BUS_CMD_AUTOINC_EN
    logic              use_next_q;
    logic [ADDR_W-1:0] last_addr_q;
`endif

    assign rx_ok = rx_valid & frame;

    // Address of the request about to issue; the last READ byte is taken straight off rx_data.
    always_comb begin
        cmd_addr_d = {a16_q, addr_hi_q, (state_q == ST_ADDR_LO) ? rx_data : addr_lo_q};
`ifdef BUS_CMD_AUTOINC_EN
        if (use_next_q || state_q == ST_IDLE)
            cmd_addr_d = last_addr_q + 1'b1;
`endif
    end

    always_comb begin
        issue_d    = 1'b0;
        issue_rd_d = 1'b0;
        if (rx_ok) begin
            case (state_q)
                ST_ADDR_LO: begin
                    issue_d    = is_rd_q;
                    issue_rd_d = is_rd_q;
                end
                ST_DATA: issue_d = 1'b1;
`ifdef BUS_CMD_AUTOINC_EN
                ST_IDLE: begin
                    issue_d    = (op_base(rx_data) == OP_READ_NEXT);
                    issue_rd_d = (op_base(rx_data) == OP_READ_NEXT);
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            is_rd_q     <= 1'b0;
            a16_q       <= 1'b0;
            addr_hi_q   <= '0;
            addr_lo_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_rw_b_q  <= 1'b1;
            pending_q   <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef BUS_CMD_AUTOINC_EN
            use_next_q  <= 1'b0;
            last_addr_q <= '1;
`endif
        end else begin
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_ok) begin
                        a16_q <= rx_data[0];
`ifdef BUS_CMD_AUTOINC_EN
                        use_next_q <= 1'b0;
`endif
                        if (op_base(rx_data) == OP_WRITE) begin
                            is_rd_q <= 1'b0;
                            state_q <= ST_ADDR_HI;
                        end else if (op_base(rx_data) == OP_READ) begin
                            is_rd_q <= 1'b1;
                            state_q <= ST_ADDR_HI;
`ifdef BUS_CMD_AUTOINC_EN
                        end else if (op_base(rx_data) == OP_WRITE_NEXT) begin
                            is_rd_q    <= 1'b0;
                            use_next_q <= 1'b1;
                            state_q    <= ST_DATA;
                        end else if (op_base(rx_data) == OP_READ_NEXT) begin
                            is_rd_q <= 1'b1;
`else
                        end else if (op_base(rx_data) == OP_WRITE_NEXT ||
                                     op_base(rx_data) == OP_READ_NEXT) begin
                            state_q <= ST_DRAIN;
`endif
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_ADDR_HI: begin
                    if (!frame) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid) begin
                        addr_hi_q <= rx_data;
                        state_q   <= ST_ADDR_LO;
                    end
                end
                ST_ADDR_LO: begin
                    if (!frame) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid) begin
                        addr_lo_q <= rx_data;
                        if (!is_rd_q)
                            state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!frame)
                        state_q <= ST_IDLE;
                end
                ST_ISSUE: begin
                    // frame dropping here does not abort: the sync stage is already committed
                    if (done) begin
                        pending_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        if (bus_rw_b_q) begin
                            tx_data_q  <= bus_rdata;
                            tx_valid_q <= 1'b1;
                        end
                    end
                    if (rx_ok)
                        overrun_q <= 1'b1;
                end
                ST_DRAIN: begin
                    if (!frame)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (issue_d) begin
                bus_addr_q <= cmd_addr_d;
                bus_rw_b_q <= issue_rd_d;
                if (!issue_rd_d)
                    bus_wdata_q <= rx_data;
                pending_q  <= 1'b1;
                state_q    <= ST_ISSUE;
`ifdef BUS_CMD_AUTOINC_EN
                last_addr_q <= cmd_addr_d;
`endif
            end
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_rw_b  = bus_rw_b_q;
    assign pending   = pending_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign overrun   = overrun_q;

endmodule
